// File: rtl/stg_if_if.sv
// Bundle between stage-1 fetch, the instruction memory and stage 2 (stg_xt).
// Occupancy debug signals expose the fetch queue state to observers.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef OPC_NOP
`define OPC_NOP 16'hF000
`endif

interface stg_if_if;
  logic [`SIZE_ADDR-1:0] ow_mem_addr;
  logic                  ow_mem_en;
  logic [`SIZE_DATA-1:0] iw_mem_data;
  logic                  iw_flush;
  logic [`SIZE_ADDR-1:0] iw_flush_pc;
  logic                  iw_stall;
  logic [`SIZE_ADDR-1:0] ow_pc;
  logic [`SIZE_DATA-1:0] ow_instr;
  logic [7:0]            ow_dbg_cnt;
  logic                  ow_dbg_inflight;

  // Handshake: ow_instr/ow_pc are valid every cycle (NOP when empty);
  // iw_stall is the downstream not-ready and freezes them; memory read data
  // is valid exactly one edge after the edge that sampled ow_mem_en=1.
  modport master (
    output ow_mem_addr, ow_mem_en, ow_pc, ow_instr, ow_dbg_cnt, ow_dbg_inflight,
    input  iw_mem_data, iw_flush, iw_flush_pc, iw_stall
  );

  modport slave (
    input  ow_mem_addr, ow_mem_en, ow_pc, ow_instr, ow_dbg_cnt, ow_dbg_inflight,
    output iw_mem_data, iw_flush, iw_flush_pc, iw_stall
  );
endinterface

// File: rtl/stg_if.sv
// Stage 1 instruction fetch: owns the fetch PC, issues memory reads and feeds
// one instruction per cycle to stg_xt through a small latency-absorbing queue.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef OPC_NOP
`define OPC_NOP 16'hF000
`endif

module stg_if #(
  parameter logic [`SIZE_ADDR-1:0] RESET_PC = '0,
  parameter int                    DEPTH    = 2
) (
  input  logic        iw_clk,
  input  logic        iw_rst,
  stg_if_if.master    bus
);

  localparam int A     = `SIZE_ADDR;
  localparam int D     = `SIZE_DATA;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [D-1:0]     NOP     = {`OPC_NOP, 16'b0};
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

  logic [A-1:0]     fpc_q, fpc_d;
  logic             inflight_q, inflight_d;
  logic [A-1:0]     ipc_q, ipc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [A-1:0]     pc_q, pc_d;
  logic [D-1:0]     instr_q, instr_d;

  logic [A-1:0]     qpc_q  [DEPTH];
  logic [D-1:0]     qdat_q [DEPTH];

  logic             avail, pop, head_pop, resp, bypass, push, mem_en;
  logic [CNT_W:0]   occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Occupancy counts the in-flight read so a stalled pipe never overfills.
  always_comb begin
    avail    = (cnt_q != '0) || inflight_q;
    pop      = !bus.iw_flush && !bus.iw_stall && avail;
    head_pop = pop && (cnt_q != '0);
    resp     = inflight_q && !bus.iw_flush;
    bypass   = resp && (cnt_q == '0) && pop;
    push     = resp && !bypass;
    occ      = {1'b0, cnt_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    mem_en   = !iw_rst && !bus.iw_flush && (occ < DEPTH_W);
  end

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = mem_en;
    ipc_d      = ipc_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;

    if (mem_en) begin
      ipc_d = fpc_q;
      fpc_d = fpc_q + 1'b1;
    end

    if (bus.iw_flush) begin
      fpc_d   = bus.iw_flush_pc;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      pc_d    = '0;
      instr_d = NOP;
    end else begin
      if (pop) begin
        if (head_pop) begin
          pc_d    = qpc_q[rd_q];
          instr_d = qdat_q[rd_q];
          rd_d    = ptr_inc(rd_q);
        end else begin
          pc_d    = ipc_q;
          instr_d = bus.iw_mem_data;
        end
      end else if (!bus.iw_stall) begin
        instr_d = NOP;
      end
      if (push) begin
        wr_d = ptr_inc(wr_q);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(head_pop);
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      ipc_q      <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      pc_q       <= '0;
      instr_q    <= NOP;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      ipc_q      <= ipc_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  // Queue storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst && !bus.iw_flush && push) begin
      qpc_q[wr_q]  <= ipc_q;
      qdat_q[wr_q] <= bus.iw_mem_data;
    end
  end

  assign bus.ow_mem_addr     = fpc_q;
  assign bus.ow_mem_en       = mem_en;
  assign bus.ow_pc           = pc_q;
  assign bus.ow_instr        = instr_q;
  assign bus.ow_dbg_cnt      = 8'(cnt_q);
  assign bus.ow_dbg_inflight = inflight_q;

endmodule
